tribus_arbiter: RTL and testbench

- Controller for a shared 8-bit tristate bus built from N tribuf instances.
- Generates the per-driver enables that feed each tribuf `c` input, using round-robin arbitration.
- Enables are guaranteed never to overlap; a forced all-off turnaround separates any two owners.
- Also samples the resolved bus wire and presents the data as a registered receive stream, so it sits both upstream (enables) and downstream (capture) of the tristate buffers.

---
 rtl/tribus_pkg.sv | 30 +++
 rtl/tribus_arbiter_rr_pick.sv | 39 +++
 rtl/tribus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_tribus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tribus_pkg.sv
// Shared types and default sizing for the tristate bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package tribus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    localparam int DEF_N        = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_MAX_HOLD = 4;
    localparam int DEF_TURN_CYC = 1;

    // Index of (ptr + k) modulo n, with k < n and ptr < n.
    function automatic int unsigned wrap_add(
        input int unsigned ptr,
        input int unsigned k,
        input int unsigned n
    );
        int unsigned s;
        s = ptr + k;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping at N. Unknown request bits never win.
module rr_pick
    import tribus_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] sel_o,
    output logic          any_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        sel_o = '0;
        any_o = 1'b0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req_i[idx]) begin
                found = 1'b1;
                sel_o = idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin enable generator for N tribuf drivers on a shared bus,
// with a forced all-off turnaround and a registered receive capture.
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = DEF_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int TURN_CYC = DEF_TURN_CYC,
    parameter int IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic [W-1:0]  bus_in,
    output logic [N-1:0]  en,
    output logic [N-1:0]  gnt,
    output logic          busy,
    output logic [W-1:0]  rx_data,
    output logic          rx_valid,
    output logic [IW-1:0] rx_src
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
    localparam logic [IW-1:0] PTR_LAST  = IW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  en_q, en_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] turn_q, turn_d;
    logic          busy_q, busy_d;
    logic [W-1:0]  rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic [IW-1:0] rx_src_q, rx_src_d;

    logic [IW-1:0] sel;
    logic [IW-1:0] ptr_nxt;
    logic          any;
    logic          keep;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .sel_o (sel),
        .any_o (any)
    );

    assign ptr_nxt = (sel == PTR_LAST) ? '0 : sel + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            en_q       <= '0;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            turn_q     <= '0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_src_q   <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_src_q   <= rx_src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        busy_d  = busy_q;
        keep    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                en_d   = '0;
                gnt_d  = '0;
                busy_d = 1'b0;
                if (any) begin
                    state_d = ST_DRIVE;
                    en_d    = N'(1) << sel;
                    gnt_d   = N'(1) << sel;
                    owner_d = sel;
                    ptr_d   = ptr_nxt;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_DRIVE: begin
                hold_d = hold_q + HW'(1);
                // An unknown req bit falls through to release the bus.
                if (req[owner_q] && (hold_q != HOLD_LAST)) begin
                    keep = 1'b1;
                end
                if (!keep) begin
                    state_d = ST_TURN;
                    en_d    = '0;
                    gnt_d   = '0;
                    turn_d  = '0;
                end
            end
            ST_TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = ST_IDLE;
                    turn_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = '0;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_src_d   = rx_src_q;
        rx_valid_d = 1'b0;
        if (|en_q) begin
            rx_data_d  = bus_in;
            rx_src_d   = owner_q;
            rx_valid_d = 1'b1;
        end
    end

    assign en       = en_q;
    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_src   = rx_src_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Bench for tribus_arbiter: default instance plus a TURN_CYC=3 instance,
// tribuf bus model, and a cycle-stamped receive scoreboard.
module tb_tribus_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] req3 = '0;
    logic [W-1:0] bus, bus3;
    logic [N-1:0] en, gnt, en3, gnt3;
    logic         busy, busy3;
    logic [W-1:0] rx_data, rx_data3;
    logic         rx_valid, rx_valid3;
    logic [1:0]   rx_src, rx_src3;
    logic [W-1:0] drv_data [N];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   src;
        int           due;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    tribus_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .bus_in   (bus),
        .en       (en),
        .gnt      (gnt),
        .busy     (busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_src   (rx_src)
    );

    tribus_arbiter #(.TURN_CYC(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req3),
        .bus_in   (bus3),
        .en       (en3),
        .gnt      (gnt3),
        .busy     (busy3),
        .rx_data  (rx_data3),
        .rx_valid (rx_valid3),
        .rx_src   (rx_src3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        bus = 'z;
        for (int i = 0; i < N; i++) if (en[i]) bus = drv_data[i];
    end

    always_comb begin
        bus3 = 'z;
        for (int i = 0; i < N; i++) if (en3[i]) bus3 = drv_data[i];
    end

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            checks++;
            if (!$onehot0(en) || gnt !== en) begin
                failures++;
                $display("FAIL en_onehot cyc=%0d en=%b gnt=%b", cyc, en, gnt);
            end
            checks++;
            if (q1.size() != 0 && q1[0].due == cyc) begin
                if (rx_valid !== 1'b1 || rx_data !== q1[0].data ||
                    rx_src !== q1[0].src) begin
                    failures++;
                    $display("FAIL rx cyc=%0d got v=%b d=%h s=%0d exp v=1 d=%h s=%0d",
                             cyc, rx_valid, rx_data, rx_src, q1[0].data, q1[0].src);
                end
                void'(q1.pop_front());
            end else if (rx_valid !== 1'b0) begin
                failures++;
                $display("FAIL rx_spurious cyc=%0d got v=%b exp v=0", cyc, rx_valid);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            checks++;
            if (!$onehot0(en3) || gnt3 !== en3) begin
                failures++;
                $display("FAIL en3_onehot cyc=%0d en=%b gnt=%b", cyc, en3, gnt3);
            end
            checks++;
            if (q3.size() != 0 && q3[0].due == cyc) begin
                if (rx_valid3 !== 1'b1 || rx_data3 !== q3[0].data ||
                    rx_src3 !== q3[0].src) begin
                    failures++;
                    $display("FAIL rx3 cyc=%0d got v=%b d=%h s=%0d exp v=1 d=%h s=%0d",
                             cyc, rx_valid3, rx_data3, rx_src3, q3[0].data, q3[0].src);
                end
                void'(q3.pop_front());
            end else if (rx_valid3 !== 1'b0) begin
                failures++;
                $display("FAIL rx3_spurious cyc=%0d got v=%b exp v=0", cyc, rx_valid3);
            end
        end
    end

    task automatic apply_reset();
        req  = '0;
        req3 = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        q1.delete();
        q3.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (en !== '0 || gnt !== '0 || busy !== 1'b0 || rx_valid !== 1'b0 ||
            rx_data !== '0 || rx_src !== '0) begin
            failures++;
            $display("FAIL reset_outputs en=%b gnt=%b busy=%b v=%b d=%h s=%0d exp all 0",
                     en, gnt, busy, rx_valid, rx_data, rx_src);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (en !== '0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle k=%0d en=%b busy=%b exp 0", k, en, busy);
            end
        end
    endtask

    task automatic test_single();
        logic [N-1:0] exp_en [9];
        logic [8:0]   exp_busy;
        apply_reset();
        exp_en   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                     4'b0000, 4'b0001, 4'b0000, 4'b0000};
        exp_busy = 9'b011011111;
        drv_data[0] = 8'h3C;
        req = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks++;
            if (en !== exp_en[k] || busy !== exp_busy[k]) begin
                failures++;
                $display("FAIL single k=%0d en=%b busy=%b exp en=%b busy=%b",
                         k, en, busy, exp_en[k], exp_busy[k]);
            end
            if (exp_en[k] != '0) q1.push_back('{drv_data[0], 2'd0, cyc + 1});
            if (k == 6) req = '0;
        end
        @(negedge clk);
        #2;
        checks++;
        if (q1.size() != 0) begin
            failures++;
            $display("FAIL single_rx_left got=%0d exp=0", q1.size());
        end
    endtask

    task automatic test_fair();
        logic [N-1:0] exp;
        int           o;
        apply_reset();
        for (int i = 0; i < N; i++) drv_data[i] = 8'hA0 + 8'(i);
        req = 4'b1111;
        for (int k = 0; k < 27; k++) begin
            o = (k / 6) % 4;
            exp = (k <= 24 && (k % 6) < 4) ? 4'(1 << o) : 4'b0000;
            @(negedge clk);
            checks++;
            if (en !== exp) begin
                failures++;
                $display("FAIL fair k=%0d en=%b exp=%b", k, en, exp);
            end
            if (exp != '0) q1.push_back('{drv_data[o], 2'(o), cyc + 1});
            if (k == 24) req = '0;
        end
        @(negedge clk);
        #2;
        checks++;
        if (q1.size() != 0) begin
            failures++;
            $display("FAIL fair_rx_left got=%0d exp=0", q1.size());
        end
    endtask

    task automatic test_early_release();
        logic [N-1:0] exp_en [4];
        apply_reset();
        exp_en = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
        drv_data[2] = 8'h5A;
        req = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (en !== exp_en[k]) begin
                failures++;
                $display("FAIL early k=%0d en=%b exp=%b", k, en, exp_en[k]);
            end
            if (exp_en[k] != '0) q1.push_back('{drv_data[2], 2'd2, cyc + 1});
            if (k == 1) req = '0;
        end
        @(negedge clk);
        #2;
        checks++;
        if (q1.size() != 0) begin
            failures++;
            $display("FAIL early_rx_left got=%0d exp=0", q1.size());
        end
    endtask

    task automatic test_rr_ptr();
        logic [N-1:0] exp_en [9];
        apply_reset();
        exp_en = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                   4'b0000, 4'b0001, 4'b0000, 4'b0000};
        drv_data[0] = 8'hC3;
        drv_data[1] = 8'h96;
        req = 4'b0010;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks++;
            if (en !== exp_en[k]) begin
                failures++;
                $display("FAIL rr_ptr k=%0d en=%b exp=%b", k, en, exp_en[k]);
            end
            if (k < 4) q1.push_back('{drv_data[1], 2'd1, cyc + 1});
            if (k == 6) q1.push_back('{drv_data[0], 2'd0, cyc + 1});
            if (k == 4) req = 4'b0011;
            if (k == 6) req = '0;
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drv_data[0] = 8'h77;
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (en !== 4'b0001) begin
            failures++;
            $display("FAIL areset_pre en=%b exp=0001", en);
        end
        q1.push_back('{drv_data[0], 2'd0, cyc + 1});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (en !== '0 || gnt !== '0 || rx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL areset_async en=%b gnt=%b v=%b busy=%b exp all 0",
                     en, gnt, rx_valid, busy);
        end
        req = '0;
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (en !== '0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL areset_idle k=%0d en=%b busy=%b exp 0", k, en, busy);
            end
        end
    endtask

    task automatic test_turnaround();
        logic [N-1:0] exp_en [13];
        apply_reset();
        exp_en = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                   4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000,
                   4'b0000, 4'b0000, 4'b0000};
        drv_data[0] = 8'h11;
        drv_data[1] = 8'h22;
        req3 = 4'b0011;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            checks++;
            if (en3 !== exp_en[k]) begin
                failures++;
                $display("FAIL turn k=%0d en=%b exp=%b", k, en3, exp_en[k]);
            end
            if (k < 4) q3.push_back('{drv_data[0], 2'd0, cyc + 1});
            if (k == 8) q3.push_back('{drv_data[1], 2'd1, cyc + 1});
            if (k == 8) req3 = '0;
        end
        @(negedge clk);
        #2;
        checks++;
        if (q3.size() != 0) begin
            failures++;
            $display("FAIL turn_rx_left got=%0d exp=0", q3.size());
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) drv_data[i] = '0;
        test_reset();
        test_single();
        test_fair();
        test_early_release();
        test_rr_ptr();
        test_async_reset();
        test_turnaround();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
